// File: rtl/mem_pkg.sv
// Shared types and default widths for the unified-memory arbiter.
package mem_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} arb_state_t;
    typedef enum logic {SEL_I, SEL_D} port_sel_t;

endpackage

// File: rtl/arb_prio.sv
// Fixed D-over-I priority select with a saturating streak counter that
// forces an I grant once D has won MAX_D_STREAK times while I was waiting.
module arb_prio
    import mem_pkg::*;
#(
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      i_req,
    input  logic      d_req,
    input  logic      grant,
    output port_sel_t sel
);

    localparam logic [3:0] MaxStreak = 4'(MAX_D_STREAK);

    logic [3:0] streak;
    logic       starved;

    assign starved = i_req && (streak == MaxStreak);

    always_comb begin
        sel = SEL_I;
        if (d_req && !starved) begin
            sel = SEL_D;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            streak <= '0;
        end else if (grant) begin
            if (sel == SEL_D && i_req) begin
                if (streak != MaxStreak) begin
                    streak <= streak + 4'd1;
                end
            end else begin
                streak <= '0;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises instruction-fetch and data accesses onto one single-ported memory;
// every output is registered and each access returns a one-cycle ready pulse.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd,
    input  logic              mem_valid
);

    arb_state_t state;
    port_sel_t  sel;
    logic       grant;

    // Requests are still held during the ready cycle, so no grant is taken then.
    assign grant = (state == IDLE) && !i_ready && !d_ready && (i_req || d_req);

    arb_prio #(
        .MAX_D_STREAK(MAX_D_STREAK)
    ) u_arb_prio (
        .clk  (clk),
        .reset(reset),
        .i_req(i_req),
        .d_req(d_req),
        .grant(grant),
        .sel  (sel)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            i_ready  <= 1'b0;
            d_ready  <= 1'b0;
            i_rdata  <= '0;
            d_rdata  <= '0;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_wd   <= '0;
        end else begin
            mem_req <= 1'b0;
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant) begin
                        mem_req <= 1'b1;
                        if (sel == SEL_D) begin
                            mem_addr <= d_addr;
                            mem_we   <= d_we;
                            mem_wd   <= d_wdata;
                            state    <= BUSY_D;
                        end else begin
                            mem_addr <= i_addr;
                            mem_we   <= 1'b0;
                            state    <= BUSY_I;
                        end
                    end
                end
                BUSY_I: begin
                    if (mem_valid) begin
                        i_rdata <= mem_rd;
                        i_ready <= 1'b1;
                        state   <= IDLE;
                    end
                end
                BUSY_D: begin
                    if (mem_valid) begin
                        if (!mem_we) begin
                            d_rdata <= mem_rd;
                        end
                        d_ready <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of single accesses plus hand-written
// sequences for cycle timing, contention, starvation, reset and stray completions.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_ready, d_ready, mem_req, mem_we, mem_valid;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wd, mem_rd;

    logic        model_valid, spur_valid, model_en;
    logic [31:0] model_rd, spur_rd;
    int          mem_delay;
    logic [31:0] mem [0:63];

    assign mem_valid = model_valid | spur_valid;
    assign mem_rd    = spur_valid ? spur_rd : model_rd;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        int          cyc;
    } grant_t;
    grant_t gq[$];

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [31:0] exp_wd;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int i_rdy_cnt = 0;
    int d_rdy_cnt = 0;
    int d_rdy_cyc = 0;

    mem_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .MAX_D_STREAK(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_ready  (i_ready),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ready  (d_ready),
        .d_rdata  (d_rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wd   (mem_wd),
        .mem_rd   (mem_rd),
        .mem_valid(mem_valid)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Grant log and ready counters, sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        if (mem_req) gq.push_back('{mem_we, mem_addr, mem_wd, cyc});
        if (i_ready) i_rdy_cnt++;
        if (d_ready) begin
            d_rdy_cnt++;
            d_rdy_cyc = cyc;
        end
    end

    // Memory model: completes mem_delay cycles after the command strobe.
    initial begin
        bit          pend;
        bit          pw;
        int          cnt;
        logic [31:0] pa, pd;
        pend = 0; cnt = 0; pw = 0; pa = '0; pd = '0;
        model_valid = 1'b0;
        model_rd = '0;
        forever begin
            @(negedge clk);
            model_valid = 1'b0;
            if (pend) begin
                if (cnt <= 1) begin
                    model_valid = 1'b1;
                    if (pw) begin
                        mem[pa[7:2]] = pd;
                        model_rd = 32'hFFFF_FFFF;
                    end else begin
                        model_rd = mem[pa[7:2]];
                    end
                    pend = 0;
                end else begin
                    cnt--;
                end
            end
            if (mem_req && model_en) begin
                pend = 1; cnt = mem_delay; pa = mem_addr; pw = mem_we; pd = mem_wd;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic do_xact(input bit is_d, input bit we, input logic [31:0] addr,
                           input logic [31:0] wd, output logic [31:0] rdata);
        bit done = 0;
        rdata = '0;
        if (is_d) begin
            d_we = we; d_addr = addr; d_wdata = wd; d_req = 1'b1;
        end else begin
            i_addr = addr; i_req = 1'b1;
        end
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (is_d ? d_ready : i_ready) begin
                rdata = is_d ? d_rdata : i_rdata;
                done = 1;
                break;
            end
        end
        if (is_d) d_req = 1'b0;
        else i_req = 1'b0;
        check(is_d ? "d_xact_done" : "i_xact_done", 32'(done), 32'd1);
    endtask

    initial begin
        vec_t        vecs[6];
        logic [31:0] rd, rd2;
        int          exp_seq[8];
        int          ir0, dr0;
        bit          seen;

        i_req = 0; d_req = 0; d_we = 0; i_addr = '0; d_addr = '0; d_wdata = '0;
        spur_valid = 0; spur_rd = '0; model_en = 1; mem_delay = 1;
        for (int k = 0; k < 64; k++) mem[k] = 32'h0;
        mem[4]  = 32'h2008_0005;
        mem[32] = 32'h2400_0001;
        mem[48] = 32'h0000_BEEF;

        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_i_ready", 32'(i_ready), 0);
        check("rst_d_ready", 32'(d_ready), 0);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_rdata", i_rdata | d_rdata | mem_wd, 0);
        reset = 1'b0;
        @(negedge clk);

        // Cycle-exact single fetch: memory answers the cycle after mem_req.
        gq.delete();
        dr0 = d_rdy_cnt;
        i_addr = 32'h10; i_req = 1'b1;
        @(negedge clk);
        check("fetch_c1_mem_req", 32'(mem_req), 1);
        check("fetch_c1_mem_we", 32'(mem_we), 0);
        check("fetch_c1_mem_addr", mem_addr, 32'h10);
        @(negedge clk);
        check("fetch_c2_mem_req", 32'(mem_req), 0);
        check("fetch_c2_i_ready", 32'(i_ready), 0);
        @(negedge clk);
        check("fetch_c3_i_ready", 32'(i_ready), 1);
        check("fetch_c3_i_rdata", i_rdata, 32'h2008_0005);
        i_req = 1'b0;
        @(negedge clk);
        check("fetch_c4_i_ready", 32'(i_ready), 0);
        repeat (3) @(negedge clk);
        check("fetch_no_d_ready", 32'(d_rdy_cnt - dr0), 0);
        check("fetch_one_grant", 32'(gq.size()), 1);

        // Table of single accesses with a 2-cycle memory.
        mem_delay = 2;
        vecs[0] = '{0, 0, 32'h10, 32'h0,         32'h2008_0005, 32'h0};
        vecs[1] = '{1, 1, 32'h54, 32'h7,         32'h0,         32'h7};
        vecs[2] = '{1, 0, 32'h54, 32'hAAAA_0000, 32'h7,         32'hAAAA_0000};
        vecs[3] = '{0, 0, 32'h54, 32'h0,         32'h7,         32'hAAAA_0000};
        vecs[4] = '{1, 1, 32'h20, 32'h1234_5678, 32'h7,         32'h1234_5678};
        vecs[5] = '{0, 0, 32'h20, 32'h0,         32'h1234_5678, 32'h1234_5678};
        for (int v = 0; v < 6; v++) begin
            gq.delete();
            ir0 = i_rdy_cnt; dr0 = d_rdy_cnt;
            do_xact(vecs[v].is_d, vecs[v].we, vecs[v].addr, vecs[v].wdata, rd);
            repeat (2) @(negedge clk);
            check($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rdata);
            check($sformatf("vec%0d_grants", v), 32'(gq.size()), 1);
            if (gq.size() > 0) begin
                check($sformatf("vec%0d_mem_we", v), 32'(gq[0].we),
                      32'(vecs[v].is_d & vecs[v].we));
                check($sformatf("vec%0d_mem_addr", v), gq[0].addr, vecs[v].addr);
                check($sformatf("vec%0d_mem_wd", v), gq[0].wd, vecs[v].exp_wd);
            end
            check($sformatf("vec%0d_other_ready", v),
                  32'(vecs[v].is_d ? i_rdy_cnt - ir0 : d_rdy_cnt - dr0), 0);
        end

        // Contention: D wins, I granted in the IDLE cycle after d_ready.
        gq.delete();
        fork
            do_xact(1, 0, 32'hC0, 32'h0, rd);
            do_xact(0, 0, 32'h80, 32'h0, rd2);
        join
        check("cont_d_rdata", rd, 32'h0000_BEEF);
        check("cont_i_rdata", rd2, 32'h2400_0001);
        check("cont_grants", 32'(gq.size()), 2);
        if (gq.size() == 2) begin
            check("cont_first_addr", gq[0].addr, 32'hC0);
            check("cont_second_addr", gq[1].addr, 32'h80);
            check("cont_i_grant_cycle", 32'(gq[1].cyc - d_rdy_cyc), 2);
        end

        // Starvation guard: I held while D keeps re-requesting.
        do_reset();
        gq.delete();
        exp_seq = '{'hC0, 'hC0, 'hC0, 'hC0, 'h80, 'hC0, 'hC0, 'h80};
        fork
            begin
                for (int k = 0; k < 6; k++) do_xact(1, 0, 32'hC0, 32'h0, rd);
            end
            begin
                for (int k = 0; k < 2; k++) do_xact(0, 0, 32'h80, 32'h0, rd2);
            end
        join
        check("starve_grants", 32'(gq.size()), 8);
        for (int k = 0; k < 8 && k < gq.size(); k++) begin
            check($sformatf("starve_grant%0d_addr", k), gq[k].addr, 32'(exp_seq[k]));
        end

        // Reset one cycle after a D grant, then a late completion.
        model_en = 0;
        dr0 = d_rdy_cnt;
        d_we = 0; d_addr = 32'hC0; d_req = 1'b1;
        seen = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (mem_req) begin
                seen = 1;
                break;
            end
        end
        check("rstop_grant_seen", 32'(seen), 1);
        reset = 1'b1; d_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("rstop_mem_req", 32'(mem_req), 0);
        check("rstop_mem_addr", mem_addr, 0);
        check("rstop_d_rdata", d_rdata, 0);
        @(negedge clk);
        spur_rd = 32'h1234_0000; spur_valid = 1'b1;
        @(negedge clk);
        spur_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rstop_no_d_ready", 32'(d_rdy_cnt - dr0), 0);
        check("rstop_d_rdata_after", d_rdata, 0);
        model_en = 1;

        // Stray completion while IDLE.
        do_xact(0, 0, 32'h10, 32'h0, rd);
        repeat (2) @(negedge clk);
        gq.delete();
        ir0 = i_rdy_cnt; dr0 = d_rdy_cnt;
        spur_rd = 32'hDEAD_BEEF; spur_valid = 1'b1;
        @(negedge clk);
        spur_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("spur_no_ready", 32'((i_rdy_cnt - ir0) + (d_rdy_cnt - dr0)), 0);
        check("spur_i_rdata", i_rdata, 32'h2008_0005);
        check("spur_d_rdata", d_rdata, 0);
        check("spur_no_mem_req", 32'(gq.size()), 0);
        // An FSM left busy would accept this completion; IDLE must grant anew.
        do_xact(1, 0, 32'h54, 32'h0, rd);
        check("spur_next_load", rd, 32'h7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
